// File: rtl/add_sub_pkg.sv
// Shared opcode definitions for the add/subtract/accumulate block.
package add_sub_pkg;

   localparam int OP_WIDTH = 3;

   typedef enum logic [OP_WIDTH-1:0] {
      ADD     = 3'd0,
      SUB     = 3'd1,
      ACC_ADD = 3'd2,
      ACC_SUB = 3'd3,
      ACC_CLR = 3'd4
   } op_e;

endpackage

// File: rtl/add_sub_acc_if.sv
// Request/response bus of add_sub_acc: valid/ready in both directions plus flags and counter.
interface add_sub_acc_if
   import add_sub_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int ACC_WIDTH  = DATA_WIDTH + 4,
   parameter int CNT_WIDTH  = 16
);

   logic                  en;
   logic                  in_valid;
   logic                  in_ready;
   logic [OP_WIDTH-1:0]   op;
   logic [DATA_WIDTH-1:0] data1;
   logic [DATA_WIDTH-1:0] data2;
   logic                  out_valid;
   logic                  out_ready;
   logic [ACC_WIDTH-1:0]  data_out;
   logic                  flag_carry;
   logic                  flag_zero;
   logic                  flag_err;
   logic [CNT_WIDTH-1:0]  op_count;

   modport master (
      output en, in_valid, op, data1, data2, out_ready,
      input  in_ready, out_valid, data_out, flag_carry, flag_zero, flag_err, op_count
   );

   modport slave (
      input  en, in_valid, op, data1, data2, out_ready,
      output in_ready, out_valid, data_out, flag_carry, flag_zero, flag_err, op_count
   );

endinterface

// File: rtl/add_sub_core.sv
// Combinational datapath: operand add/sub, accumulator update with wrap or clamp, result flags.
module add_sub_core
   import add_sub_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int ACC_WIDTH  = DATA_WIDTH + 4,
   parameter int SATURATE   = 0
) (
   input  logic [OP_WIDTH-1:0]   op_i,
   input  logic [DATA_WIDTH-1:0] data1_i,
   input  logic [DATA_WIDTH-1:0] data2_i,
   input  logic [ACC_WIDTH-1:0]  acc_i,
   output logic [ACC_WIDTH-1:0]  res_o,
   output logic [ACC_WIDTH-1:0]  acc_o,
   output logic                  acc_we_o,
   output logic                  carry_o,
   output logic                  zero_o,
   output logic                  err_o
);

   localparam int EW = ACC_WIDTH + 1;

   logic [DATA_WIDTH:0] sum;
   logic [DATA_WIDTH:0] diff;
   logic [ACC_WIDTH:0]  acc_up;
   logic [ACC_WIDTH:0]  acc_dn;
   logic [ACC_WIDTH-1:0] acc_nxt;

   // Bit ACC_WIDTH of the extended result flags overflow (up) or underflow (down).
   function automatic logic [ACC_WIDTH-1:0] clamp(input logic [ACC_WIDTH:0] ext, input logic up);
      if ((SATURATE != 0) && ext[ACC_WIDTH])
         return {ACC_WIDTH{up}};
      return ext[ACC_WIDTH-1:0];
   endfunction

   assign sum    = {1'b0, data1_i} + {1'b0, data2_i};
   assign diff   = {1'b0, data1_i} - {1'b0, data2_i};
   assign acc_up = {1'b0, acc_i} + EW'(data1_i);
   assign acc_dn = {1'b0, acc_i} - EW'(data1_i);

   always_comb begin
      res_o    = '0;
      acc_nxt  = acc_i;
      acc_we_o = 1'b0;
      carry_o  = 1'b0;
      err_o    = 1'b0;
      case (op_i)
         ADD: begin
            res_o   = ACC_WIDTH'(sum);
            carry_o = sum[DATA_WIDTH];
         end
         SUB: begin
            res_o   = ACC_WIDTH'(diff);
            carry_o = diff[DATA_WIDTH];
         end
         ACC_ADD: begin
            acc_nxt  = clamp(acc_up, 1'b1);
            acc_we_o = 1'b1;
            res_o    = acc_nxt;
            carry_o  = acc_up[ACC_WIDTH];
         end
         ACC_SUB: begin
            acc_nxt  = clamp(acc_dn, 1'b0);
            acc_we_o = 1'b1;
            res_o    = acc_nxt;
            carry_o  = acc_dn[ACC_WIDTH];
         end
         ACC_CLR: begin
            acc_nxt  = '0;
            acc_we_o = 1'b1;
         end
         default: err_o = 1'b1;
      endcase
   end

   assign acc_o  = acc_nxt;
   assign zero_o = (res_o == '0);

endmodule

// File: rtl/add_sub_acc.sv
// Handshaked add/subtract/accumulate unit: one-deep output register, accumulator and op counter.
module add_sub_acc
   import add_sub_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int ACC_WIDTH  = DATA_WIDTH + 4,
   parameter int SATURATE   = 0,
   parameter int CNT_WIDTH  = 16
) (
   input  logic          clk,
   input  logic          rst,
   add_sub_acc_if.slave  bus
);

   logic                 out_valid_q, out_valid_d;
   logic [ACC_WIDTH-1:0] data_q, data_d;
   logic                 carry_q, carry_d;
   logic                 zero_q, zero_d;
   logic                 err_q, err_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic [ACC_WIDTH-1:0] core_res;
   logic [ACC_WIDTH-1:0] core_acc;
   logic                 core_acc_we;
   logic                 core_carry;
   logic                 core_zero;
   logic                 core_err;
   logic                 in_ready;
   logic                 accept;

   add_sub_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .SATURATE   (SATURATE)
   ) u_core (
      .op_i     (bus.op),
      .data1_i  (bus.data1),
      .data2_i  (bus.data2),
      .acc_i    (acc_q),
      .res_o    (core_res),
      .acc_o    (core_acc),
      .acc_we_o (core_acc_we),
      .carry_o  (core_carry),
      .zero_o   (core_zero),
      .err_o    (core_err)
   );

   // The output register frees up in the same cycle it drains, giving full throughput.
   assign in_ready = bus.en && !rst && (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      data_d      = data_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      err_d       = err_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      if (accept) begin
         out_valid_d = 1'b1;
         data_d      = core_res;
         carry_d     = core_carry;
         zero_d      = core_zero;
         err_d       = core_err;
         acc_d       = core_acc_we ? core_acc : acc_q;
         cnt_d       = cnt_q + CNT_WIDTH'(1);
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // ---- output / state register stage ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         data_q      <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         err_q       <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         data_q      <= data_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         err_q       <= err_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.data_out   = data_q;
   assign bus.flag_carry = carry_q;
   assign bus.flag_zero  = zero_q;
   assign bus.flag_err   = err_q;
   assign bus.op_count   = cnt_q;

endmodule

// File: tb/tb_add_sub_acc.sv
// Directed bench for add_sub_acc: one saturating and one wrapping instance on a shared clock.
module tb_add_sub_acc;
   import add_sub_pkg::*;

   localparam int DW = 4;
   localparam int AW = 8;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   add_sub_acc_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) bs ();
   add_sub_acc_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) bw ();

   add_sub_acc #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(1), .CNT_WIDTH(CW)) dut_sat (
      .clk (clk), .rst (rst), .bus (bs)
   );
   add_sub_acc #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(0), .CNT_WIDTH(CW)) dut_wrap (
      .clk (clk), .rst (rst), .bus (bw)
   );

   // {out_valid, flag_err, flag_carry, flag_zero, data_out}
   logic [11:0] obs_s, obs_w;
   assign obs_s = {bs.out_valid, bs.flag_err, bs.flag_carry, bs.flag_zero, bs.data_out};
   assign obs_w = {bw.out_valid, bw.flag_err, bw.flag_carry, bw.flag_zero, bw.data_out};

   int vectors     = 0;
   int miscompares = 0;
   int cnt_s       = 0;

   task automatic issue_s(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
      bs.op = o; bs.data1 = a; bs.data2 = b; bs.in_valid = 1'b1;
      @(posedge clk); #1;
      bs.in_valid = 1'b0;
      cnt_s++;
   endtask

   task automatic issue_w(input logic [2:0] o, input logic [3:0] a);
      bw.op = o; bw.data1 = a; bw.data2 = 4'd0; bw.in_valid = 1'b1;
      @(posedge clk); #1;
      bw.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      vectors++; if (obs_s !== 12'h000) begin miscompares++; $display("FAIL reset_sat_out got %h want %h", obs_s, 12'h000); end
      vectors++; if (obs_w !== 12'h000) begin miscompares++; $display("FAIL reset_wrap_out got %h want %h", obs_w, 12'h000); end
      vectors++; if (bs.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", bs.in_ready); end
      vectors++; if (bs.op_count !== 16'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", bs.op_count); end
      #10 rst = 1'b0;
      @(posedge clk); #1;
      vectors++; if (bs.in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready got %b want 1", bs.in_ready); end
   endtask

   task automatic test_add_sub();
      issue_s(ADD, 4'd9, 4'd8);
      vectors++; if (obs_s !== 12'hA11) begin miscompares++; $display("FAIL add_9_8 got %h want %h", obs_s, 12'hA11); end
      issue_s(SUB, 4'd3, 4'd5);
      vectors++; if (obs_s !== 12'hA1E) begin miscompares++; $display("FAIL sub_3_5 got %h want %h", obs_s, 12'hA1E); end
      issue_s(ADD, 4'd0, 4'd0);
      vectors++; if (obs_s !== 12'h900) begin miscompares++; $display("FAIL add_0_0 got %h want %h", obs_s, 12'h900); end
      issue_s(SUB, 4'd12, 4'd5);
      vectors++; if (obs_s !== 12'h807) begin miscompares++; $display("FAIL sub_12_5 got %h want %h", obs_s, 12'h807); end
      vectors++; if (bs.op_count !== 16'(cnt_s)) begin miscompares++; $display("FAIL count_add_sub got %0d want %0d", bs.op_count, cnt_s); end
   endtask

   task automatic test_saturate();
      logic [11:0] exp;
      issue_s(ACC_CLR, 4'd0, 4'd0);
      vectors++; if (obs_s !== 12'h900) begin miscompares++; $display("FAIL acc_clr got %h want %h", obs_s, 12'h900); end
      for (int i = 1; i <= 18; i++) begin
         issue_s(ACC_ADD, 4'd15, 4'd0);
         exp = (i == 18) ? 12'hAFF : {4'h8, 8'(15 * i)};
         vectors++; if (obs_s !== exp) begin miscompares++; $display("FAIL sat_add_%0d got %h want %h", i, obs_s, exp); end
      end
      issue_s(ACC_CLR, 4'd0, 4'd0);
      issue_s(ACC_SUB, 4'd15, 4'd0);
      vectors++; if (obs_s !== 12'hB00) begin miscompares++; $display("FAIL sat_sub_floor got %h want %h", obs_s, 12'hB00); end
   endtask

   task automatic test_illegal();
      issue_s(ACC_CLR, 4'd0, 4'd0);
      issue_s(ACC_ADD, 4'd15, 4'd0);
      issue_s(ACC_ADD, 4'd15, 4'd0);
      issue_s(ACC_ADD, 4'd2, 4'd0);
      vectors++; if (obs_s !== 12'h820) begin miscompares++; $display("FAIL acc_0x20 got %h want %h", obs_s, 12'h820); end
      issue_s(3'd6, 4'd7, 4'd7);
      vectors++; if (obs_s !== 12'hD00) begin miscompares++; $display("FAIL illegal_op6 got %h want %h", obs_s, 12'hD00); end
      vectors++; if (bs.op_count !== 16'(cnt_s)) begin miscompares++; $display("FAIL illegal_count got %0d want %0d", bs.op_count, cnt_s); end
      issue_s(ADD, 4'd1, 4'd1);
      vectors++; if (obs_s !== 12'h802) begin miscompares++; $display("FAIL add_1_1 got %h want %h", obs_s, 12'h802); end
      issue_s(ACC_ADD, 4'd0, 4'd0);
      vectors++; if (obs_s !== 12'h820) begin miscompares++; $display("FAIL acc_kept got %h want %h", obs_s, 12'h820); end
   endtask

   task automatic test_backpressure();
      bs.in_valid = 1'b0;
      @(posedge clk); #1;
      bs.out_ready = 1'b0;
      issue_s(ADD, 4'd1, 4'd2);
      vectors++; if (obs_s !== 12'h803) begin miscompares++; $display("FAIL bp_first got %h want %h", obs_s, 12'h803); end
      bs.op = ADD; bs.data1 = 4'd4; bs.data2 = 4'd5; bs.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         vectors++; if (bs.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_%0d got %b want 0", i, bs.in_ready); end
         @(posedge clk); #1;
         vectors++; if (obs_s !== 12'h803) begin miscompares++; $display("FAIL bp_hold_%0d got %h want %h", i, obs_s, 12'h803); end
         vectors++; if (bs.op_count !== 16'(cnt_s)) begin miscompares++; $display("FAIL bp_count_%0d got %0d want %0d", i, bs.op_count, cnt_s); end
      end
      bs.out_ready = 1'b1;
      #1;
      vectors++; if (bs.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got %b want 1", bs.in_ready); end
      @(posedge clk); #1;
      bs.in_valid = 1'b0;
      cnt_s++;
      vectors++; if (obs_s !== 12'h809) begin miscompares++; $display("FAIL bp_drain_accept got %h want %h", obs_s, 12'h809); end
      vectors++; if (bs.op_count !== 16'(cnt_s)) begin miscompares++; $display("FAIL bp_count_after got %0d want %0d", bs.op_count, cnt_s); end
      @(posedge clk); #1;
      vectors++; if (bs.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain_only got %b want 0", bs.out_valid); end
      bs.en = 1'b0;
      #1;
      vectors++; if (bs.in_ready !== 1'b0) begin miscompares++; $display("FAIL en_low_ready got %b want 0", bs.in_ready); end
      bs.en = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      issue_w(ACC_CLR, 4'd0);
      for (int i = 0; i < 16; i++) issue_w(ACC_ADD, 4'd15);
      issue_w(ACC_ADD, 4'd10);
      vectors++; if (obs_w !== 12'h8FA) begin miscompares++; $display("FAIL wrap_pre got %h want %h", obs_w, 12'h8FA); end
      issue_w(ACC_ADD, 4'd10);
      vectors++; if (obs_w !== 12'hA04) begin miscompares++; $display("FAIL wrap_over got %h want %h", obs_w, 12'hA04); end
      issue_w(ACC_SUB, 4'd5);
      vectors++; if (obs_w !== 12'hAFF) begin miscompares++; $display("FAIL wrap_under got %h want %h", obs_w, 12'hAFF); end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #3 rst = 1'b1;
      #1 rst = 1'b0;
      cnt_s = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) issue_s(ACC_ADD, 4'd15, 4'd0);
      issue_s(ACC_ADD, 4'd4, 4'd0);
      vectors++; if (obs_s !== 12'h840) begin miscompares++; $display("FAIL rm_pre got %h want %h", obs_s, 12'h840); end
      vectors++; if (bs.op_count !== 16'd5) begin miscompares++; $display("FAIL rm_pre_count got %0d want 5", bs.op_count); end
      #2 rst = 1'b1;
      #1;
      vectors++; if (obs_s !== 12'h000) begin miscompares++; $display("FAIL rm_async_out got %h want %h", obs_s, 12'h000); end
      vectors++; if (bs.op_count !== 16'd0) begin miscompares++; $display("FAIL rm_async_count got %0d want 0", bs.op_count); end
      vectors++; if (bs.in_ready !== 1'b0) begin miscompares++; $display("FAIL rm_in_ready got %b want 0", bs.in_ready); end
      #1 rst = 1'b0;
      cnt_s = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         vectors++; if (bs.out_valid !== 1'b0) begin miscompares++; $display("FAIL rm_idle_%0d got %b want 0", i, bs.out_valid); end
      end
      issue_s(ACC_ADD, 4'd1, 4'd0);
      vectors++; if (obs_s !== 12'h801) begin miscompares++; $display("FAIL rm_new got %h want %h", obs_s, 12'h801); end
      vectors++; if (bs.op_count !== 16'd1) begin miscompares++; $display("FAIL rm_new_count got %0d want 1", bs.op_count); end
   endtask

   initial begin
      bs.en = 1'b1; bs.in_valid = 1'b0; bs.out_ready = 1'b1;
      bs.op = ADD; bs.data1 = '0; bs.data2 = '0;
      bw.en = 1'b1; bw.in_valid = 1'b0; bw.out_ready = 1'b1;
      bw.op = ADD; bw.data1 = '0; bw.data2 = '0;
      test_reset();
      test_add_sub();
      test_saturate();
      test_illegal();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/add_sub_acc.md
ADD_SUB_ACC -- requirements
Module: add_sub_acc

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, operand width (>=2).
REQ-002 The block SHALL have parameter ACC_WIDTH, default DATA_WIDTH+4, accumulator and result width (>=DATA_WIDTH+1).
REQ-003 The block SHALL have parameter SATURATE, default 0; 1 = accumulator clamps, 0 = accumulator wraps.
REQ-004 The block SHALL have parameter CNT_WIDTH, default 16, transaction-counter width.
REQ-005 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 en  in  1  global enable; low blocks input acceptance only.
REQ-009 in_valid  in  1  request valid.
REQ-010 in_ready  out  1  request accepted when in_valid && in_ready.
REQ-011 op  in  3  operation code (op_e).
REQ-012 data1, data2  in  DATA_WIDTH each  unsigned operands.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  downstream accepts result.
REQ-015 data_out  out  ACC_WIDTH  result.
REQ-016 flag_carry, flag_zero, flag_err  out  1 each  result flags, qualified by out_valid.
REQ-017 op_count  out  CNT_WIDTH  accepted transactions, wraps.

Function
REQ-018 in_ready SHALL equal en && (!out_valid || out_ready); combinational, full throughput.
REQ-019 Accepted request SHALL produce out_valid on the next rising edge (latency 1).
REQ-020 While out_valid && !out_ready, data_out and flags SHALL hold stable.
REQ-021 Drain and accept in the same cycle SHALL load the new result with out_valid staying 1.
REQ-022 out_valid SHALL clear on drain without accept.
REQ-023 ADD (0): data_out = zero-extended {carry, data1+data2} over DATA_WIDTH+1 bits; flag_carry = bit DATA_WIDTH.
REQ-024 SUB (1): data_out = zero-extended (data1-data2) mod 2^(DATA_WIDTH+1); flag_carry = borrow (data1<data2).
REQ-025 ACC_ADD (2): acc <= acc+data1; data_out = new acc; flag_carry = overflow past 2^ACC_WIDTH-1.
REQ-026 ACC_SUB (3): acc <= acc-data1; data_out = new acc; flag_carry = underflow below 0.
REQ-027 On ACC overflow/underflow: SATURATE=1 SHALL clamp to 2^ACC_WIDTH-1 / 0; SATURATE=0 SHALL wrap modulo 2^ACC_WIDTH.
REQ-028 ACC_CLR (4): acc <= 0; data_out = 0; flag_carry = 0.
REQ-029 Ops 5-7 SHALL set flag_err=1, data_out=0, flag_carry=0, acc unchanged; flag_err=0 for legal ops.
REQ-030 flag_zero SHALL be 1 iff data_out == 0.
REQ-031 acc and op_count SHALL update only on accept; ADD/SUB SHALL not touch acc.
REQ-032 op_count SHALL increment by 1 per accept, including illegal ops, wrapping at 2^CNT_WIDTH.

Reset
REQ-033 rst high SHALL immediately force out_valid=0, data_out=0, all flags 0, acc=0, op_count=0, regardless of clock.
REQ-034 Reset mid-transaction SHALL discard the pending result; no output SHALL appear after deassertion without a new accept.
REQ-035 in_ready SHALL be 0 while rst is high.

Structure
REQ-036 Package add_sub_pkg SHALL hold op_e (ADD, SUB, ACC_ADD, ACC_SUB, ACC_CLR) and OP_WIDTH=3.
REQ-037 Combinational arithmetic and flag generation SHALL sit in sub-module add_sub_core; handshake, acc, counter and output registers in add_sub_acc.

Verification (DATA_WIDTH=4, ACC_WIDTH=8)
REQ-038 ADD 9+8 -> next cycle data_out=0x11, flag_carry=1, flag_zero=0; SUB 3-5 -> data_out=0x1E, flag_carry=1.
REQ-039 SATURATE=1: ACC_CLR, then 18x ACC_ADD 15 -> 17th gives 0xFF carry=0, 18th 0xFF carry=1; ACC_SUB 15 from 0 -> 0x00, carry=1, zero=1.
REQ-040 SATURATE=0: acc=0xFA, ACC_ADD 10 -> data_out=0x04, flag_carry=1.
REQ-041 ADD 1+2 accepted, out_ready low 3 cycles -> data_out=3 held, in_ready=0, next request waits; out_ready high -> drain and accept in same cycle.
REQ-042 Op 6 with acc=0x20 -> flag_err=1, data_out=0, flag_zero=1, acc stays 0x20, op_count +1.
REQ-043 rst pulsed between edges with out_valid=1, acc=0x40, op_count=5 -> all outputs 0 at once; no out_valid after release until new accept.
